modbus_rtu_frame_rx: RTL and testbench
======================================

// Module: modbus_rtu_frame_rx
// PURPOSE
//  Modbus RTU frame receiver. Sits after uart_byte_rx in the slave and groups its bytes into frames using
//  t1.5/t3.5 silence timing. Stores each frame in an internal byte buffer and checks CRC-16/MODBUS on the fly.
//  Flags frame completion to the request decoder, which reads the buffer back.
// PARAMETERS
//  CLK_FREQ      50000000  system clock, Hz
//  BAUD_RATE     115200    line baud rate
//  MAX_FRAME_LEN 256       buffer depth, bytes (power of 2, <=256)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active high
//  rx_data     in   8   byte from uart_byte_rx, valid when rx_done=1
//  rx_done     in   1   one-cycle byte-received strobe
//  slave_addr  in   8   own station address (used only with ADDR_FILTER_EN)
//  rd_addr     in   8   buffer read address
//  rd_data     out  8   buffer[rd_addr], registered, 1-cycle latency
//  frame_done  out  1   one-cycle pulse: frame closed, status valid
//  frame_len   out  9   byte count of closed frame, CRC bytes included
//  crc_ok      out  1   closed frame CRC correct and frame_err=0
//  frame_err   out  1   closed frame has overflow, t1.5 gap violation or len<4
//  busy        out  1   high in RECV/GAP
// BEHAVIOUR
//  Reset: all outputs 0; state INIT; timer 0; CRC 16'hFFFF; write pointer 0.
//  Timing: BIT = CLK_FREQ/BAUD_RATE. BAUD_RATE<=19200: T15=BIT*33/2, T35=BIT*77/2 clks.
//   Otherwise fixed T15=CLK_FREQ/1000000*750, T35=CLK_FREQ/1000000*1750 clks.
//   Silence timer clears on every rx_done and saturates at T35.
//  States:
//   INIT : waits for T35 of silence before accepting frames; any rx_done is discarded and restarts timer; ->IDLE.
//   IDLE : rx_done -> write byte at addr 0, len=1, CRC update, err=0, ->RECV.
//   RECV : rx_done -> store at len (if len<MAX_FRAME_LEN, else set ovf and drop byte), len++, CRC update.
//          timer==T15 without byte -> GAP.
//   GAP  : rx_done -> set err (gap violation), byte not stored, timer restarts; stay GAP.
//          timer==T35 -> DONE.
//   DONE : one cycle; frame_done=1; frame_len/crc_ok/frame_err load; ->IDLE.
//  CRC: poly 0xA001 reflected, init 0xFFFF, one full byte per rx_done (combinational 8-step unroll).
//   crc_ok=1 iff final CRC==16'h0000, len>=4, no ovf, no gap error.
//  frame_len counts every byte received in RECV, including dropped overflow bytes; saturates at 511.
//  frame_len/crc_ok/frame_err hold until the next DONE. Buffer is overwritten from addr 0 when the next frame starts.
//  Simultaneous rx_done and timer reaching T15 (or T35): the byte wins, counts as in-time, timer clears.
//  Read port works in any state; rd_addr>=frame_len returns stale contents (no error).
//  Reset asserted mid-frame: frame abandoned, no frame_done, state back to INIT.
// CONFIGURATION
//  ADDR_FILTER_EN defined:
//   - a frame whose byte0 is neither slave_addr nor 8'h00 (broadcast) is dropped silently: no frame_done,
//     status outputs unchanged.
//   - the remainder of that frame is still timed, so the next frame is delimited correctly.
//  Undefined: every frame produces frame_done; slave_addr is ignored.
// TESTING  (CLK_FREQ=50 MHz, 115200 baud: T15=37500, T35=87500 clks; stimulus via uart_byte_tx->uart_byte_rx)
//  1. Reset, idle 90000 clks, send 01 03 00 00 00 01 84 0A -> frame_done ~87500 clks after last byte;
//     frame_len=8, crc_ok=1, frame_err=0; rd_addr 0..7 returns the bytes.
//  2. Same frame with last byte 0B -> frame_done, frame_len=8, crc_ok=0, frame_err=0.
//  3. Send 01 03, wait 50000 clks, send 00 -> single frame_done; frame_len=2, frame_err=1, crc_ok=0.
//  4. Drive rx_done 300 times, 1000 clks apart -> frame_len=300, frame_err=1;
//     buffer holds the first 256 bytes only.
//  5. Bytes during INIT (before 87500 idle clks after reset) -> no frame_done.
//     Assert rst during RECV -> outputs 0, no frame_done.
//  6. ADDR_FILTER_EN, slave_addr=8'h11:
//     - frame 01 .. -> no frame_done.
//     - frame 00 06 00 01 00 03 99 DA -> frame_done, crc_ok=1.
//     - frame 11 .. with valid CRC -> frame_done.

Source files
------------

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver: t1.5/t3.5 silence framing, byte buffer, CRC-16/MODBUS; ADDR_FILTER_EN drops frames for other stations.
// Latency: frame_done 1 clk after the t3.5 silence completes; rd_data 1 clk after rd_addr.
// Backpressure: none; every rx_done strobe is consumed in the cycle it arrives.
module modbus_rtu_frame_rx #(
    parameter int CLK_FREQ      = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int MAX_FRAME_LEN = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic [7:0] slave_addr,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_done,
    output logic [8:0] frame_len,
    output logic       crc_ok,
    output logic       frame_err,
    output logic       busy
);

    localparam int BIT = CLK_FREQ / BAUD_RATE;
    localparam int T15 = (BAUD_RATE <= 19200) ? BIT * 33 / 2 : CLK_FREQ / 1000000 * 750;
    localparam int T35 = (BAUD_RATE <= 19200) ? BIT * 77 / 2 : CLK_FREQ / 1000000 * 1750;
    localparam int TW  = $clog2(T35 + 1);
    localparam int AW  = $clog2(MAX_FRAME_LEN);
    localparam logic [TW-1:0] T15_CNT = TW'(T15);
    localparam logic [TW-1:0] T35_CNT = TW'(T35);
    localparam logic [8:0]    MAX_LEN = 9'(MAX_FRAME_LEN);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RECV, S_GAP, S_DONE} state_t;

    state_t        state, next_state;
    logic [TW-1:0] timer;
    logic [15:0]   crc;
    logic [8:0]    len;
    logic          ovf;
    logic          gap_err;
    logic          drop;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          closing;
    logic          close_err;
    logic [7:0]    mem [MAX_FRAME_LEN];

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // A byte arriving on the same cycle the timer hits a threshold wins.
    always_comb begin
        next_state = state;
        case (state)
            S_INIT: if (!rx_done && timer == T35_CNT) next_state = S_IDLE;
            S_IDLE: if (rx_done) next_state = S_RECV;
            S_RECV: if (!rx_done && timer == T15_CNT) next_state = S_GAP;
            S_GAP:  if (!rx_done && timer == T35_CNT) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_INIT;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (rx_done && state == S_IDLE) begin
            wr_en = 1'b1;
        end else if (rx_done && state == S_RECV && len < MAX_LEN) begin
            wr_en   = 1'b1;
            wr_addr = len[AW-1:0];
        end
    end

    assign closing   = (state == S_GAP) && (next_state == S_DONE);
    assign close_err = ovf | gap_err | (len < 9'd4);
    assign busy      = (state == S_RECV) || (state == S_GAP);

`ifndef ADDR_FILTER_EN
    logic unused_slave_addr;
    assign unused_slave_addr = ^slave_addr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            timer      <= '0;
            crc        <= 16'hFFFF;
            len        <= '0;
            ovf        <= 1'b0;
            gap_err    <= 1'b0;
            drop       <= 1'b0;
            rd_data    <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            crc_ok     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= next_state;
            rd_data    <= mem[rd_addr[AW-1:0]];
            frame_done <= 1'b0;
            if (rx_done) begin
                timer <= '0;
            end else if (timer != T35_CNT) begin
                timer <= timer + 1'b1;
            end
            if (rx_done && state == S_IDLE) begin
                len     <= 9'd1;
                crc     <= crc_step(16'hFFFF, rx_data);
                ovf     <= 1'b0;
                gap_err <= 1'b0;
`ifdef ADDR_FILTER_EN
                drop    <= (rx_data != slave_addr) && (rx_data != 8'h00);
`else
                drop    <= 1'b0;
`endif
            end
            if (rx_done && state == S_RECV) begin
                if (len >= MAX_LEN) ovf <= 1'b1;
                if (len != 9'h1FF) len <= len + 9'd1;
                crc <= crc_step(crc, rx_data);
            end
            if (rx_done && state == S_GAP) begin
                gap_err <= 1'b1;
            end
            if (closing && !drop) begin
                frame_done <= 1'b1;
                frame_len  <= len;
                frame_err  <= close_err;
                crc_ok     <= (crc == 16'h0000) && !close_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= rx_data;
    end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Bench for modbus_rtu_frame_rx at 1 MHz / 115200 baud (T15=750, T35=1750 clks) so whole frames fit in a short run.
// A gap-distance model predicts every cycle's status; directed frames add literal expectations.
module tb_modbus_rtu_frame_rx;

    localparam int T15  = 750;
    localparam int T35  = 1750;
    localparam int MAXL = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] slave_addr = 8'h11;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       frame_done;
    logic [8:0] frame_len;
    logic       crc_ok;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    modbus_rtu_frame_rx #(
        .CLK_FREQ(1000000),
        .BAUD_RATE(115200),
        .MAX_FRAME_LEN(MAXL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .slave_addr(slave_addr),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .frame_done(frame_done),
        .frame_len(frame_len),
        .crc_ok(crc_ok),
        .frame_err(frame_err),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int snap;

    // Model: frames are delimited purely by the distance (in clock edges) between strobes.
    int          mcyc = 0;
    int          mlast = 0;
    int          mph = 0;  // 0 waiting for initial silence, 1 ready, 2 in frame, 3 closing cycle
    int          mcnt = 0;
    bit          mgap = 1'b0;
    bit          movf = 1'b0;
    logic [15:0] mcrc = 16'hFFFF;
    logic [7:0]  mb0 = 8'h00;
    logic        e_fd = 1'b0;
    logic [8:0]  e_len = 9'd0;
    logic        e_ok = 1'b0;
    logic        e_err = 1'b0;
    bit          accept;
    logic [7:0]  fq[$];

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 16'hA001 : 16'h0000);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mlast = mcyc;
                mph   = 0;
                e_fd  = 1'b0;
                e_len = 9'd0;
                e_ok  = 1'b0;
                e_err = 1'b0;
            end else begin
                mcyc++;
                e_fd = 1'b0;
                case (mph)
                    0: begin
                        if (rx_done) mlast = mcyc;
                        else if (mcyc - mlast == T35 + 1) mph = 1;
                    end
                    1: begin
                        if (rx_done) begin
                            mcnt  = 1;
                            mcrc  = crc_upd(16'hFFFF, rx_data);
                            mgap  = 1'b0;
                            movf  = 1'b0;
                            mb0   = rx_data;
                            mlast = mcyc;
                            mph   = 2;
                        end
                    end
                    2: begin
                        if (rx_done) begin
                            if (mcyc - mlast <= T15 + 1) begin
                                if (mcnt >= MAXL) movf = 1'b1;
                                if (mcnt < 511) mcnt++;
                                mcrc = crc_upd(mcrc, rx_data);
                            end else begin
                                mgap = 1'b1;
                            end
                            mlast = mcyc;
                        end else if (mcyc - mlast == T35 + 1) begin
`ifdef ADDR_FILTER_EN
                            accept = (mb0 == slave_addr) || (mb0 == 8'h00);
`else
                            accept = 1'b1;
`endif
                            if (accept) begin
                                e_fd  = 1'b1;
                                e_len = 9'(mcnt);
                                e_err = movf || mgap || (mcnt < 4);
                                e_ok  = (mcrc == 16'h0000) && !e_err;
                            end
                            mph = 3;
                        end
                    end
                    default: mph = 1;
                endcase
            end
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            chk("cycle_status", {19'd0, frame_done, busy, frame_len, crc_ok, frame_err},
                {19'd0, e_fd, (mph == 2), e_len, e_ok, e_err});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input int spacing);
        foreach (fq[i]) begin
            send_byte(fq[i]);
            idle(spacing - 2);
        end
    endtask

    task automatic read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic status_chk(input string name, input int cnt, input int len, input bit ok, input bit err);
        chk({name, "_count"}, fd_cnt, cnt);
        chk({name, "_len"}, {23'd0, frame_len}, len);
        chk({name, "_crc_ok"}, {31'd0, crc_ok}, {31'd0, ok});
        chk({name, "_err"}, {31'd0, frame_err}, {31'd0, err});
    endtask

    initial begin : stim
        logic [15:0] c;
        repeat (3) @(posedge clk);
        chk("reset_outputs", {18'd0, frame_done, busy, frame_len, crc_ok, frame_err, rd_data}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(T35 + 10);

        // Valid read holding registers request
        fq = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        send_frame(20);
        idle(T35 + 20);
        status_chk("good_frame", 1, 8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) read_chk("good_frame_buf", 8'(i), fq[i]);

        fq[7] = 8'h0B;
        send_frame(20);
        idle(T35 + 20);
        status_chk("bad_crc", 2, 8, 1'b0, 1'b0);

        // Third byte lands between t1.5 and t3.5
        fq = '{8'h01, 8'h03};
        send_frame(20);
        idle(1200);
        send_byte(8'h00);
        idle(T35 + 20);
        status_chk("gap_violation", 3, 2, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            send_byte((i < 256) ? 8'(i) : ~8'(i));
            idle(8);
        end
        idle(T35 + 20);
        status_chk("overflow", 4, 300, 1'b0, 1'b1);
        read_chk("overflow_buf0", 8'd0, 8'd0);
        read_chk("overflow_buf100", 8'd100, 8'd100);
        read_chk("overflow_buf255", 8'd255, 8'd255);

        // Frame for another station
        fq = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        send_frame(20);
        idle(T35 + 20);
`ifdef ADDR_FILTER_EN
        status_chk("filtered", 4, 300, 1'b0, 1'b1);
`else
        status_chk("unfiltered", 5, 8, 1'b1, 1'b0);
`endif
        snap = fd_cnt;
        fq = '{8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h99, 8'hDA};
        send_frame(20);
        idle(T35 + 20);
        status_chk("broadcast", snap + 1, 8, 1'b1, 1'b0);
        fq = '{8'h11, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        c = 16'hFFFF;
        foreach (fq[i]) c = crc_upd(c, fq[i]);
        fq.push_back(c[7:0]);
        fq.push_back(c[15:8]);
        send_frame(20);
        idle(T35 + 20);
        status_chk("own_addr", snap + 2, 8, 1'b1, 1'b0);

        // Bytes before the initial t3.5 silence are discarded
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        snap = fd_cnt;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h01);
            idle(498);
        end
        idle(T35 + 20);
        chk("init_discard_count", fd_cnt, snap);

        fq = '{8'h01, 8'h03, 8'h00};
        send_frame(20);
        chk("recv_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("mid_frame_reset", {18'd0, frame_done, busy, frame_len, crc_ok, frame_err, rd_data}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(T35 + 50);
        chk("mid_frame_reset_count", fd_cnt, snap);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
